alu_op_sequencer: RTL and testbench
===================================

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand width in bits.
REQ-002 SHALL have ports, one per line as follows (clock and reset first):
  CLK  in  1  clock, all state updates on rising edge.
  RST  in  1  reset, synchronous, active-low.
  IN_VALID  in  1  upstream operation request valid.
  IN_READY  out  1  sequencer can accept an operation.
  A, B  in  WIDTH each  operands.
  ALU_FUN  in  4  [3:2] unit select (00 arith, 01 logic, 10 cmp, 11 shift); [1:0] sub-function.
  A_R, B_R  out  WIDTH each  latched operands driven to units.
  FUN_R  out  2  latched ALU_FUN[1:0] driven to units.
  ARITH_Enable, LOGIC_Enable, CMP_Enable, SHIFT_Enable  out  1 each  unit enables.
  ARITH_OUT  in  2*WIDTH  registered arith result.
  LOGIC_OUT, CMP_OUT, SHIFT_OUT  in  WIDTH each  registered unit results.
  RES_OUT  out  2*WIDTH  captured result; WIDTH-wide unit results zero-extended.
  RES_UNIT  out  2  unit select of the captured result.
  RES_VALID  out  1  result valid.
  RES_READY  in  1  downstream accepts result.
  OP_COUNT  out  8  count of completed result handshakes.

Function
REQ-003 SHALL implement FSM states IDLE, ISSUE, CAPTURE, HOLD.
REQ-004 IN_READY SHALL be 1 only in IDLE.
REQ-005 IDLE: on IN_VALID=1, SHALL latch A, B, ALU_FUN into A_R, B_R, FUN_R, and the selected unit, then go to ISSUE. Otherwise SHALL stay in IDLE.
REQ-006 ISSUE (exactly one cycle): SHALL assert only the enable decoded from the latched ALU_FUN[3:2], then go to CAPTURE.
REQ-007 CAPTURE (exactly one cycle): all enables SHALL be 0. SHALL register the selected unit's output into RES_OUT and the latched select into RES_UNIT, then go to HOLD.
REQ-008 HOLD: RES_VALID SHALL be 1. RES_OUT and RES_UNIT SHALL be stable. On RES_READY=1, SHALL go to IDLE and increment OP_COUNT.
REQ-009 RES_VALID SHALL be 0 in all states other than HOLD.
REQ-010 Latency SHALL be 3 cycles: acceptance edge to the first cycle of RES_VALID=1. Maximum throughput SHALL be one operation per 4 cycles.
REQ-011 A_R, B_R and FUN_R SHALL hold their values from acceptance until the next acceptance.
REQ-012 OP_COUNT SHALL wrap from 255 to 0.
REQ-013 IN_VALID during ISSUE, CAPTURE or HOLD SHALL be ignored (no acceptance). Upstream SHALL keep it asserted.
REQ-014 RES_READY outside HOLD SHALL have no effect.
REQ-015 Unit result inputs SHALL be sampled only in CAPTURE. Changes in any other state SHALL not affect RES_OUT.

Reset
REQ-016 On RST=0 at a rising CLK edge, in any state including mid-operation: FSM SHALL go to IDLE; A_R, B_R, FUN_R, RES_OUT, RES_UNIT, OP_COUNT SHALL be 0; all enables and RES_VALID SHALL be 0.
REQ-017 In the first cycle after RST returns to 1, IN_READY SHALL be 1. An operation interrupted by reset SHALL be discarded without a result.

Structure
REQ-018 A shared package alu_pkg SHALL hold the unit-select encodings (ARITH, LOGIC, CMP, SHIFT) and the FSM state encoding.
REQ-019 Unit-select decode to one-hot enables SHALL be the sub-module alu_fun_decoder (combinational). It is reused by the top-level ALU.
REQ-020 All other logic SHALL reside in alu_op_sequencer.

Verification
REQ-021 WIDTH=4, A=5, B=5, ALU_FUN=4'b1001, cmp model returns 1 -> CMP_Enable high exactly one cycle; RES_VALID at acceptance+3; RES_OUT=8'h01, RES_UNIT=2'b10.
REQ-022 ALU_FUN=4'b0010 (arith multiply), A=15, B=15, model returns 225 -> ARITH_Enable only; RES_OUT=8'hE1, RES_UNIT=2'b00.
REQ-023 RES_READY held 0 for 10 cycles in HOLD -> RES_VALID and RES_OUT stable; IN_READY=0; IN_VALID ignored; OP_COUNT unchanged until the RES_READY=1 handshake.
REQ-024 RST=0 asserted during CAPTURE -> next cycle all outputs 0 and FSM in IDLE; after release, IN_READY=1 and OP_COUNT=0.
REQ-025 256 back-to-back operations with RES_READY=1 constant -> one accept per 4 cycles; OP_COUNT reads 0 after the 256th handshake.
REQ-026 Unit output changed during ISSUE and HOLD but not during CAPTURE -> RES_OUT equals the value present in CAPTURE.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operation sequencer and the top-level ALU.
// Holds the unit-select encodings carried on ALU_FUN[3:2] and the sequencer
// FSM state encoding.
package alu_pkg;

  localparam int unsigned NumUnits = 4;

  typedef enum logic [1:0] {
    UnitArith = 2'b00,
    UnitLogic = 2'b01,
    UnitCmp   = 2'b10,
    UnitShift = 2'b11
  } unit_e;

  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StIssue   = 2'b01,
    StCapture = 2'b10,
    StHold    = 2'b11
  } state_e;

endpackage

// File: rtl/alu_fun_decoder.sv
// Combinational decode of a unit select into one-hot unit enables.
// Ports:
//   en_i      - qualifies the decode; all enables are 0 when low
//   unit_i    - unit select (arith, logic, cmp, shift)
//   enable_o  - one-hot enables, bit index equals the unit encoding
module alu_fun_decoder
  import alu_pkg::*;
(
  input  logic                en_i,
  input  unit_e               unit_i,
  output logic [NumUnits-1:0] enable_o
);

  always_comb begin
    enable_o = '0;
    if (en_i) begin
      unique case (unit_i)
        UnitArith: enable_o[0] = 1'b1;
        UnitLogic: enable_o[1] = 1'b1;
        UnitCmp:   enable_o[2] = 1'b1;
        UnitShift: enable_o[3] = 1'b1;
        default:   enable_o    = '0;
      endcase
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Sequences one ALU operation at a time through external functional units:
// accept (IDLE) -> enable one unit for a cycle (ISSUE) -> capture its result
// (CAPTURE) -> present it until downstream takes it (HOLD).
// Ports:
//   CLK, RST                 - clock, synchronous active-low reset
//   IN_VALID/IN_READY        - operation request handshake
//   A, B, ALU_FUN            - operands and function ([3:2] unit, [1:0] sub-function)
//   A_R, B_R, FUN_R          - latched operands / sub-function driven to the units
//   *_Enable                 - one-cycle unit enables
//   ARITH/LOGIC/CMP/SHIFT_OUT - registered unit results
//   RES_OUT, RES_UNIT        - captured result and its unit select
//   RES_VALID/RES_READY      - result handshake
//   OP_COUNT                 - wrapping count of completed result handshakes
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               IN_VALID,
  output logic               IN_READY,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [3:0]         ALU_FUN,
  output logic [WIDTH-1:0]   A_R,
  output logic [WIDTH-1:0]   B_R,
  output logic [1:0]         FUN_R,
  output logic               ARITH_Enable,
  output logic               LOGIC_Enable,
  output logic               CMP_Enable,
  output logic               SHIFT_Enable,
  input  logic [2*WIDTH-1:0] ARITH_OUT,
  input  logic [WIDTH-1:0]   LOGIC_OUT,
  input  logic [WIDTH-1:0]   CMP_OUT,
  input  logic [WIDTH-1:0]   SHIFT_OUT,
  output logic [2*WIDTH-1:0] RES_OUT,
  output logic [1:0]         RES_UNIT,
  output logic               RES_VALID,
  input  logic               RES_READY,
  output logic [7:0]         OP_COUNT
);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
  logic [1:0]           fun_q, fun_d;
  unit_e                unit_q, unit_d;
  logic [2*WIDTH-1:0]   res_q, res_d;
  unit_e                res_unit_q, res_unit_d;
  logic [7:0]           count_q, count_d;
  logic [2*WIDTH-1:0]   unit_result;
  logic [NumUnits-1:0]  enables;

  alu_fun_decoder u_decoder (
    .en_i     (state_q == StIssue),
    .unit_i   (unit_q),
    .enable_o (enables)
  );

  // Narrow unit results are zero-extended to the arith result width.
  always_comb begin
    unit_result = '0;
    unique case (unit_q)
      UnitArith: unit_result = ARITH_OUT;
      UnitLogic: unit_result = {{WIDTH{1'b0}}, LOGIC_OUT};
      UnitCmp:   unit_result = {{WIDTH{1'b0}}, CMP_OUT};
      UnitShift: unit_result = {{WIDTH{1'b0}}, SHIFT_OUT};
      default:   unit_result = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    fun_d      = fun_q;
    unit_d     = unit_q;
    res_d      = res_q;
    res_unit_d = res_unit_q;
    count_d    = count_q;
    unique case (state_q)
      StIdle: begin
        if (IN_VALID) begin
          a_d     = A;
          b_d     = B;
          fun_d   = ALU_FUN[1:0];
          unit_d  = unit_e'(ALU_FUN[3:2]);
          state_d = StIssue;
        end
      end
      StIssue: state_d = StCapture;
      StCapture: begin
        res_d      = unit_result;
        res_unit_d = unit_q;
        state_d    = StHold;
      end
      StHold: begin
        if (RES_READY) begin
          count_d = count_q + 8'd1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q    <= StIdle;
      a_q        <= '0;
      b_q        <= '0;
      fun_q      <= '0;
      unit_q     <= UnitArith;
      res_q      <= '0;
      res_unit_q <= UnitArith;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      fun_q      <= fun_d;
      unit_q     <= unit_d;
      res_q      <= res_d;
      res_unit_q <= res_unit_d;
      count_q    <= count_d;
    end
  end

  assign IN_READY     = (state_q == StIdle);
  assign RES_VALID    = (state_q == StHold);
  assign ARITH_Enable = enables[0];
  assign LOGIC_Enable = enables[1];
  assign CMP_Enable   = enables[2];
  assign SHIFT_Enable = enables[3];
  assign A_R          = a_q;
  assign B_R          = b_q;
  assign FUN_R        = fun_q;
  assign RES_OUT      = res_q;
  assign RES_UNIT     = res_unit_q;
  assign OP_COUNT     = count_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer. A behavioural model tracks each
// operation by its age since acceptance and is compared against the DUT on
// every cycle, with directed scenarios pinning literal expectations.
module tb_alu_op_sequencer;

  localparam int W = 4;

  logic           CLK = 1'b0;
  logic           RST;
  logic           IN_VALID;
  logic           IN_READY;
  logic [W-1:0]   A, B;
  logic [3:0]     ALU_FUN;
  logic [W-1:0]   A_R, B_R;
  logic [1:0]     FUN_R;
  logic           ARITH_Enable, LOGIC_Enable, CMP_Enable, SHIFT_Enable;
  logic [2*W-1:0] ARITH_OUT;
  logic [W-1:0]   LOGIC_OUT, CMP_OUT, SHIFT_OUT;
  logic [2*W-1:0] RES_OUT;
  logic [1:0]     RES_UNIT;
  logic           RES_VALID;
  logic           RES_READY;
  logic [7:0]     OP_COUNT;

  alu_op_sequencer #(.WIDTH(W)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .IN_VALID     (IN_VALID),
    .IN_READY     (IN_READY),
    .A            (A),
    .B            (B),
    .ALU_FUN      (ALU_FUN),
    .A_R          (A_R),
    .B_R          (B_R),
    .FUN_R        (FUN_R),
    .ARITH_Enable (ARITH_Enable),
    .LOGIC_Enable (LOGIC_Enable),
    .CMP_Enable   (CMP_Enable),
    .SHIFT_Enable (SHIFT_Enable),
    .ARITH_OUT    (ARITH_OUT),
    .LOGIC_OUT    (LOGIC_OUT),
    .CMP_OUT      (CMP_OUT),
    .SHIFT_OUT    (SHIFT_OUT),
    .RES_OUT      (RES_OUT),
    .RES_UNIT     (RES_UNIT),
    .RES_VALID    (RES_VALID),
    .RES_READY    (RES_READY),
    .OP_COUNT     (OP_COUNT)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  // Model: busy with age 1 = issue cycle, 2 = capture cycle, 3 = holding result.
  bit m_busy = 0;
  int m_age  = 0;
  int m_unit = 0, m_fun = 0, m_a = 0, m_b = 0;
  int m_res  = 0, m_res_unit = 0, m_count = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int unit_value(input int unit);
    case (unit)
      0:       return int'(ARITH_OUT);
      1:       return int'(LOGIC_OUT);
      2:       return int'(CMP_OUT);
      default: return int'(SHIFT_OUT);
    endcase
  endfunction

  // Apply the effect of the coming rising edge with the inputs now driven.
  task automatic model_edge();
    if (!RST) begin
      m_busy = 0; m_age = 0; m_unit = 0; m_fun = 0; m_a = 0; m_b = 0;
      m_res = 0; m_res_unit = 0; m_count = 0;
    end else if (!m_busy) begin
      if (IN_VALID) begin
        m_busy = 1; m_age = 1;
        m_a = int'(A); m_b = int'(B);
        m_fun = int'(ALU_FUN[1:0]); m_unit = int'(ALU_FUN[3:2]);
      end
    end else if (m_age == 1) begin
      m_age = 2;
    end else if (m_age == 2) begin
      m_res = unit_value(m_unit); m_res_unit = m_unit; m_age = 3;
    end else if (RES_READY) begin
      m_busy = 0; m_age = 0; m_count = (m_count + 1) % 256;
    end
  endtask

  task automatic compare();
    int exp_en;
    exp_en = (m_busy && m_age == 1) ? (1 << m_unit) : 0;
    chk("in_ready", int'(IN_READY), int'(!m_busy));
    chk("enables", int'({SHIFT_Enable, CMP_Enable, LOGIC_Enable, ARITH_Enable}), exp_en);
    chk("res_valid", int'(RES_VALID), int'(m_busy && m_age >= 3));
    chk("res_out", int'(RES_OUT), m_res);
    chk("res_unit", int'(RES_UNIT), m_res_unit);
    chk("a_r", int'(A_R), m_a);
    chk("b_r", int'(B_R), m_b);
    chk("fun_r", int'(FUN_R), m_fun);
    chk("op_count", int'(OP_COUNT), m_count);
  endtask

  task automatic tick();
    model_edge();
    @(negedge CLK);
    compare();
  endtask

  task automatic rand_units();
    ARITH_OUT = 8'($urandom);
    LOGIC_OUT = 4'($urandom);
    CMP_OUT   = 4'($urandom);
    SHIFT_OUT = 4'($urandom);
  endtask

  task automatic rand_op();
    A       = 4'($urandom);
    B       = 4'($urandom);
    ALU_FUN = 4'($urandom);
  endtask

  task automatic do_reset();
    RST = 1'b0;
    tick();
    tick();
    RST = 1'b1;
  endtask

  int saved_count;

  initial begin
    RST = 1'b0; IN_VALID = 1'b0; RES_READY = 1'b0;
    A = '0; B = '0; ALU_FUN = '0;
    ARITH_OUT = '0; LOGIC_OUT = '0; CMP_OUT = '0; SHIFT_OUT = '0;
    do_reset();
    chk("reset_in_ready", int'(IN_READY), 1);
    chk("reset_op_count", int'(OP_COUNT), 0);
    chk("reset_res_valid", int'(RES_VALID), 0);

    // Compare unit, equal operands, unit reports 1.
    IN_VALID = 1; A = 4'd5; B = 4'd5; ALU_FUN = 4'b1001;
    ARITH_OUT = 8'hA7; LOGIC_OUT = 4'hC; CMP_OUT = 4'h1; SHIFT_OUT = 4'h9;
    tick();
    chk("cmp_issue_en", int'(CMP_Enable), 1);
    IN_VALID = 0;
    tick();
    chk("cmp_capture_en", int'(CMP_Enable), 0);
    tick();
    chk("cmp_valid_at_3", int'(RES_VALID), 1);
    chk("cmp_res_out", int'(RES_OUT), 8'h01);
    chk("cmp_res_unit", int'(RES_UNIT), 2'b10);
    RES_READY = 1;
    tick();
    chk("cmp_count", int'(OP_COUNT), 1);

    // Arith multiply 15*15 = 225.
    IN_VALID = 1; A = 4'd15; B = 4'd15; ALU_FUN = 4'b0010; ARITH_OUT = 8'd225;
    tick();
    chk("mul_issue_en",
        int'({SHIFT_Enable, CMP_Enable, LOGIC_Enable, ARITH_Enable}), 4'b0001);
    IN_VALID = 0; RES_READY = 0;
    tick();
    tick();
    chk("mul_res_out", int'(RES_OUT), 8'hE1);
    chk("mul_res_unit", int'(RES_UNIT), 2'b00);

    // Stall in hold for 10 cycles with noise on every other input.
    saved_count = int'(OP_COUNT);
    for (int i = 0; i < 10; i++) begin
      IN_VALID = 1; rand_op(); rand_units();
      tick();
      chk("stall_valid", int'(RES_VALID), 1);
      chk("stall_res_out", int'(RES_OUT), 8'hE1);
      chk("stall_count", int'(OP_COUNT), saved_count);
    end
    IN_VALID = 0; RES_READY = 1;
    tick();
    chk("stall_release_count", int'(OP_COUNT), saved_count + 1);

    // Unit output differs in issue, capture and hold; only capture matters.
    IN_VALID = 1; A = 4'd3; B = 4'd4; ALU_FUN = 4'b0000; RES_READY = 0;
    tick();
    IN_VALID = 0; ARITH_OUT = 8'h11;
    tick();
    ARITH_OUT = 8'h5A;
    tick();
    ARITH_OUT = 8'h33;
    tick();
    chk("sample_capture_only", int'(RES_OUT), 8'h5A);
    RES_READY = 1;
    tick();

    // Reset while in capture discards the operation.
    IN_VALID = 1; rand_op(); rand_units();
    tick();
    IN_VALID = 0;
    tick();
    RST = 0;
    tick();
    chk("midop_reset_valid", int'(RES_VALID), 0);
    chk("midop_reset_out", int'(RES_OUT), 0);
    chk("midop_reset_count", int'(OP_COUNT), 0);
    RST = 1;
    tick();
    chk("post_reset_ready", int'(IN_READY), 1);
    chk("post_reset_count", int'(OP_COUNT), 0);

    // 256 back-to-back operations: count wraps to 0.
    do_reset();
    IN_VALID = 1; RES_READY = 1;
    for (int i = 0; i < 256 * 4; i++) begin
      rand_op(); rand_units();
      tick();
    end
    chk("wrap_count", int'(OP_COUNT), 0);
    chk("wrap_ready", int'(IN_READY), 1);

    // Randomized traffic with occasional reset.
    IN_VALID = 0; RES_READY = 0;
    tick();
    for (int i = 0; i < 600; i++) begin
      IN_VALID  = ($urandom_range(0, 2) != 0);
      RES_READY = ($urandom_range(0, 2) != 0);
      RST       = ($urandom_range(0, 59) != 0);
      rand_op(); rand_units();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
